imm_ext_arbiter: RTL



---
 rtl/imm_ext_pkg.sv | 16 +
 rtl/imm_ext_arbiter_if.sv | 30 +++
 rtl/imm_ext_unit.sv | 27 ++
 rtl/imm_ext_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared widths, FSM state encoding and extend-op encoding for the
// immediate extender arbiter.
package imm_ext_pkg;

    localparam int DEF_IMM_W = 4;
    localparam int DEF_OUT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/result bundle between the two immediate requesters, the shared
// extender and the downstream operand muxes.
interface imm_ext_arbiter_if
    import imm_ext_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic [1:0]       req;
    logic [IMM_W-1:0] imm0;
    logic [IMM_W-1:0] imm1;
    logic [1:0]       exop;
    logic [1:0]       gnt;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_id;

    // Arbiter side
    modport slave (
        input  req, imm0, imm1, exop, out_ready,
        output gnt, out_valid, out_data, out_id
    );

    // Requester / consumer side
    modport master (
        output req, imm0, imm1, exop, out_ready,
        input  gnt, out_valid, out_data, out_id
    );
endinterface

// File: rtl/imm_ext_unit.sv
// Combinational IMM_W -> OUT_W immediate extender. With IMM_EXT_SIGN_EN
// undefined, exop is ignored and every result is zero-extended.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IMM_W-1:0] imm,
    input  logic             exop,
    output logic [OUT_W-1:0] ext
);

`ifdef IMM_EXT_SIGN_EN
    always_comb begin
        ext = {{(OUT_W-IMM_W){1'b0}}, imm};
        if (exop == EXT_SIGN) begin
            ext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
        end
    end
`else
    logic unused_exop;
    assign unused_exop = exop;
    assign ext         = {{(OUT_W-IMM_W){1'b0}}, imm};
`endif

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between decode (port 0)
// and branch-offset (port 1), with a single-entry valid/ready output register.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int NREQ  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    imm_ext_arbiter_if.slave  bus
);

    state_t           state_reg, state_next;
    logic             ptr_reg, ptr_next;
    logic [OUT_W-1:0] data_reg;
    logic             id_reg;

    logic             can_accept;
    logic             win;
    logic             load;
    logic [1:0]       gnt_next;
    logic [IMM_W-1:0] sel_imm;
    logic             sel_exop;
    logic [OUT_W-1:0] ext;

    // reset_n gates acceptance so no grant leaks out while reset is held
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win        = 1'b0;
        load       = 1'b0;
        gnt_next   = 2'b00;
        can_accept = reset_n && ((state_reg == IDLE) ||
                                 ((state_reg == FULL) && bus.out_ready));
        if (can_accept && (bus.req != 2'b00)) begin
            case (bus.req)
                2'b01:   win = 1'b0;
                2'b10:   win = 1'b1;
                default: win = ptr_reg;
            endcase
            load          = 1'b1;
            gnt_next[win] = 1'b1;
            ptr_next      = ~win;
            state_next    = FULL;
        end else if ((state_reg == FULL) && bus.out_ready) begin
            state_next = IDLE;
        end
    end

    assign sel_imm  = win ? bus.imm1 : bus.imm0;
    assign sel_exop = bus.exop[win];

    imm_ext_unit #(
        .IMM_W (IMM_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .imm  (sel_imm),
        .exop (sel_exop),
        .ext  (ext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg  <= 1'b0;
            data_reg <= '0;
            id_reg   <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            if (load) begin
                data_reg <= ext;
                id_reg   <= win;
            end
        end
    end

    assign bus.gnt       = gnt_next;
    assign bus.out_valid = (state_reg == FULL);
    assign bus.out_data  = data_reg;
    assign bus.out_id    = id_reg;

    a_gnt_legal: assert property (@(posedge clk) disable iff (!reset_n)
        ($countones(bus.gnt) < NREQ) && ((bus.gnt & ~bus.req) == 2'b00));

endmodule
